cachemissctrl: RTL and testbench

Miss-handling sequencer that sits between the cache lookup pipeline and the bus interface. On a miss it latches the victim way chosen by the replacement policy and performs a writeback if that line is dirty. It then fills the line and, for exactly one cycle, drives the array-update strobes and the replacement-policy advance strobe. It stalls the pipeline from miss detection until the cycle after the update.

---
 rtl/cachemissctrl_pkg.sv | 13 +
 rtl/cachemissctrl_flop.sv | 46 ++++
 rtl/cachemissctrl.sv | 103 ++++++++++
 tb/tb_cachemissctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cachemissctrl_pkg.sv
// Shared definitions for the cache miss-handling sequencer.
package cachemissctrl_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2,
      UPDATE    = 2'd3
   } state_t;

endpackage

// File: rtl/cachemissctrl_flop.sv
// Generic synchronous-reset flops used by the miss sequencer.

// Plain register with synchronous active-high reset.
module flopr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Register the input every cycle; reset clears it.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_q <= '0;
      else         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// Enabled register with synchronous active-high reset.
module flopenr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Load only when enabled so the captured value holds otherwise.
   always_ff @(posedge i_clk) begin
      if (i_reset)   r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/cachemissctrl.sv
// Cache miss sequencer: victim capture, optional writeback, line fill,
// then a single-cycle array/replacement update.
module cachemissctrl
   import cachemissctrl_pkg::*;
#(
   parameter int unsigned NUMWAYS = 4,
   parameter int unsigned SETLEN  = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Miss,
   input  logic               FlushStage,
   input  logic [SETLEN-1:0]  PAdrSet,
   input  logic [NUMWAYS-1:0] VictimWay,
   input  logic [NUMWAYS-1:0] DirtyWay,
   input  logic               BusAck,
   output logic               BusReq,
   output logic               BusWrite,
   output logic [NUMWAYS-1:0] SelWay,
   output logic [SETLEN-1:0]  SelSet,
   output logic               SetValid,
   output logic               ClearDirty,
   output logic               LRUWriteEn,
   output logic               Stall,
   output logic               Done
);

   logic [STATE_W-1:0] w_state_q;
   state_t             w_state;
   state_t             w_next;
   logic               w_capture;
   logic               w_victim_dirty;

   // A miss is accepted only from IDLE and only when the stage is not flushed.
   assign w_capture      = (w_state == IDLE) & Miss & ~FlushStage;
   assign w_victim_dirty = |(VictimWay & DirtyWay);

   // State register.
   flopr #(.WIDTH(STATE_W)) u_state_reg (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (w_next),
      .o_q     (w_state_q)
   );

   assign w_state = state_t'(w_state_q);

   // Victim way and set are frozen at capture for the whole sequence.
   flopenr #(.WIDTH(NUMWAYS)) u_way_reg (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_capture),
      .i_d     (VictimWay),
      .o_q     (SelWay)
   );

   flopenr #(.WIDTH(SETLEN)) u_set_reg (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_capture),
      .i_d     (PAdrSet),
      .o_q     (SelSet)
   );

   // Next-state and output decode; bus transfers always run to completion.
   always_comb begin
      w_next     = w_state;
      BusReq     = 1'b0;
      BusWrite   = 1'b0;
      SetValid   = 1'b0;
      ClearDirty = 1'b0;
      LRUWriteEn = 1'b0;
      Done       = 1'b0;
      Stall      = w_capture;

      case (w_state)
         IDLE: begin
            if (w_capture) w_next = w_victim_dirty ? WRITEBACK : FILL;
         end
         WRITEBACK: begin
            BusReq   = 1'b1;
            BusWrite = 1'b1;
            Stall    = 1'b1;
            if (BusAck) w_next = FILL;
         end
         FILL: begin
            BusReq = 1'b1;
            Stall  = 1'b1;
            if (BusAck) w_next = UPDATE;
         end
         UPDATE: begin
            SetValid   = 1'b1;
            ClearDirty = 1'b1;
            Done       = 1'b1;
            LRUWriteEn = ~FlushStage;
            Stall      = 1'b1;
            w_next     = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cachemissctrl.sv
// Bench for cachemissctrl: transaction-level model plus directed literals.
module tb_cachemissctrl;
   import cachemissctrl_pkg::*;

   localparam int unsigned NUMWAYS = 4;
   localparam int unsigned SETLEN  = 9;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               Miss = 1'b0;
   logic               FlushStage = 1'b0;
   logic [SETLEN-1:0]  PAdrSet = '0;
   logic [NUMWAYS-1:0] VictimWay = '0;
   logic [NUMWAYS-1:0] DirtyWay = '0;
   logic               BusAck = 1'b0;
   logic               BusReq, BusWrite, SetValid, ClearDirty, LRUWriteEn, Stall, Done;
   logic [NUMWAYS-1:0] SelWay;
   logic [SETLEN-1:0]  SelSet;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: a miss in flight, whether its writeback is still owed,
   // whether the fill has landed, and the captured way/set.
   bit                 m_busy = 1'b0;
   bit                 m_wb = 1'b0;
   bit                 m_filled = 1'b0;
   logic [NUMWAYS-1:0] m_way = '0;
   logic [SETLEN-1:0]  m_set = '0;

   cachemissctrl #(.NUMWAYS(NUMWAYS), .SETLEN(SETLEN)) dut (
      .clk(clk), .reset(reset), .Miss(Miss), .FlushStage(FlushStage),
      .PAdrSet(PAdrSet), .VictimWay(VictimWay), .DirtyWay(DirtyWay),
      .BusAck(BusAck), .BusReq(BusReq), .BusWrite(BusWrite),
      .SelWay(SelWay), .SelSet(SelSet), .SetValid(SetValid),
      .ClearDirty(ClearDirty), .LRUWriteEn(LRUWriteEn), .Stall(Stall),
      .Done(Done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the edge, return mid-cycle.
   task automatic step(input logic rst, input logic m, input logic f,
                       input logic [SETLEN-1:0] s, input logic [NUMWAYS-1:0] v,
                       input logic [NUMWAYS-1:0] d, input logic a);
      @(posedge clk);
      #1;
      reset = rst; Miss = m; FlushStage = f; PAdrSet = s;
      VictimWay = v; DirtyWay = d; BusAck = a;
      @(negedge clk);
      #1;
   endtask

   task automatic idle_step(input logic a);
      step(1'b0, 1'b0, 1'b0, 9'h000, 4'b0000, 4'b0000, a);
   endtask

   // Compare every cycle against the model, then advance the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit upd;
         upd = m_busy && m_filled;
         chk("BusReq",     32'(BusReq),     32'(m_busy && !m_filled));
         chk("BusWrite",   32'(BusWrite),   32'(m_busy && !m_filled && m_wb));
         chk("SetValid",   32'(SetValid),   32'(upd));
         chk("ClearDirty", 32'(ClearDirty), 32'(upd));
         chk("Done",       32'(Done),       32'(upd));
         chk("LRUWriteEn", 32'(LRUWriteEn), 32'(upd && !FlushStage));
         chk("Stall",      32'(Stall),      32'(m_busy || (Miss && !FlushStage)));
         chk("SelWay",     32'(SelWay),     32'(m_way));
         chk("SelSet",     32'(SelSet),     32'(m_set));

         if (reset) begin
            m_busy = 0; m_wb = 0; m_filled = 0; m_way = '0; m_set = '0;
         end else if (!m_busy) begin
            if (Miss && !FlushStage) begin
               m_busy = 1; m_filled = 0; m_wb = |(VictimWay & DirtyWay);
               m_way = VictimWay; m_set = PAdrSet;
            end
         end else if (m_filled) begin
            m_busy = 0; m_filled = 0;
         end else if (BusAck) begin
            if (m_wb) m_wb = 0;
            else      m_filled = 1;
         end
      end
   end

   initial begin
      // Reset state.
      step(1'b1, 1'b0, 1'b0, 9'h000, 4'b0000, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b0, 9'h000, 4'b0000, 4'b0000, 1'b0);
      chk("rst_BusReq", 32'(BusReq), 32'd0);
      chk("rst_Stall",  32'(Stall),  32'd0);
      chk("rst_Done",   32'(Done),   32'd0);
      chk("rst_SelWay", 32'(SelWay), 32'd0);
      chk("rst_SelSet", 32'(SelSet), 32'd0);
      chk_en = 1'b1;

      // Clean miss.
      step(1'b0, 1'b1, 1'b0, 9'h005, 4'b0010, 4'b0000, 1'b0);
      chk("clean_c0_Stall",  32'(Stall),  32'd1);
      chk("clean_c0_BusReq", 32'(BusReq), 32'd0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 4'b0000, 4'b0000, 1'b1);
      chk("clean_c1_BusReq",   32'(BusReq),   32'd1);
      chk("clean_c1_BusWrite", 32'(BusWrite), 32'd0);
      chk("clean_c1_SelWay",   32'(SelWay),   32'h2);
      chk("clean_c1_SelSet",   32'(SelSet),   32'h5);
      idle_step(1'b0);
      chk("clean_c2_SetValid",   32'(SetValid),   32'd1);
      chk("clean_c2_ClearDirty", 32'(ClearDirty), 32'd1);
      chk("clean_c2_LRUWriteEn", 32'(LRUWriteEn), 32'd1);
      chk("clean_c2_Done",       32'(Done),       32'd1);
      chk("clean_c2_Stall",      32'(Stall),      32'd1);
      idle_step(1'b0);
      chk("clean_c3_Stall", 32'(Stall), 32'd0);
      chk("clean_c3_Done",  32'(Done),  32'd0);

      // Dirty miss, acks at cycles 3 and 6, victim inputs wiggle meanwhile,
      // flush during UPDATE suppresses only the replacement advance.
      step(1'b0, 1'b1, 1'b0, 9'h1A0, 4'b1000, 4'b1000, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         step(1'b0, 1'b0, 1'(c % 2), 9'h0F0, 4'($urandom), 4'($urandom), 1'(c == 3 || c == 6));
         chk("dirty_BusReq",   32'(BusReq),   32'd1);
         chk("dirty_BusWrite", 32'(BusWrite), (c <= 3) ? 32'd1 : 32'd0);
         chk("dirty_SelWay",   32'(SelWay),   32'h8);
      end
      step(1'b0, 1'b0, 1'b1, 9'h000, 4'b0000, 4'b0000, 1'b0);
      chk("dirty_c7_Done",       32'(Done),       32'd1);
      chk("dirty_c7_SetValid",   32'(SetValid),   32'd1);
      chk("dirty_c7_LRUWriteEn", 32'(LRUWriteEn), 32'd0);

      // Flushed miss in IDLE is dropped.
      step(1'b0, 1'b1, 1'b1, 9'h1AA, 4'b0001, 4'b0001, 1'b0);
      chk("flush_Stall", 32'(Stall), 32'd0);
      idle_step(1'b0);
      chk("flush_BusReq", 32'(BusReq), 32'd0);
      chk("flush_SelSet", 32'(SelSet), 32'h1A0);

      // Spurious ack in IDLE.
      idle_step(1'b1);
      idle_step(1'b0);
      chk("spur_BusReq", 32'(BusReq), 32'd0);

      // Victim change during FILL, then back-to-back miss after UPDATE.
      step(1'b0, 1'b1, 1'b0, 9'h011, 4'b0001, 4'b0000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 4'b0100, 4'b0100, 1'b0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 4'b0100, 4'b0100, 1'b1);
      step(1'b0, 1'b1, 1'b0, 9'h022, 4'b0100, 4'b0000, 1'b0);
      chk("b2b_upd_Done",   32'(Done),   32'd1);
      chk("b2b_upd_SelWay", 32'(SelWay), 32'h1);
      step(1'b0, 1'b1, 1'b0, 9'h033, 4'b0100, 4'b0000, 1'b0);
      chk("b2b_Stall", 32'(Stall), 32'd1);
      idle_step(1'b0);
      chk("b2b_BusReq", 32'(BusReq), 32'd1);
      chk("b2b_SelSet", 32'(SelSet), 32'h33);
      chk("b2b_SelWay", 32'(SelWay), 32'h4);

      // Reset while in FILL.
      step(1'b1, 1'b0, 1'b0, 9'h000, 4'b0000, 4'b0000, 1'b0);
      chk("rstfill_BusReq_before", 32'(BusReq), 32'd1);
      idle_step(1'b0);
      chk("rstfill_BusReq", 32'(BusReq), 32'd0);
      chk("rstfill_Done",   32'(Done),   32'd0);
      chk("rstfill_Stall",  32'(Stall),  32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [NUMWAYS-1:0] v;
         v = ($urandom_range(9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
         step(1'($urandom_range(99) == 0), 1'($urandom_range(2) == 0),
              1'($urandom_range(3) == 0), 9'($urandom), v, 4'($urandom),
              1'($urandom_range(2) == 0));
      end
      idle_step(1'b0);
      idle_step(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
